// File: rtl/fetch_queue_unit_if.sv
// Fetch-stage bundle: imem request/response, branch redirect and decode-side handshake.
// master = fetch unit, slave = environment (memory, branch unit, decode).
interface fetch_queue_unit_if #(
   parameter int XLEN = 32
);
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_resp_valid;
   logic [XLEN-1:0] imem_resp_instr;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [XLEN-1:0] out_pc_plus4;
   logic [XLEN-1:0] out_instr;

   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready,
      input  imem_resp_valid, imem_resp_instr,
      input  redirect_valid, redirect_pc,
      output out_valid, out_pc, out_pc_plus4, out_instr,
      input  out_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready,
      output imem_resp_valid, imem_resp_instr,
      output redirect_valid, redirect_pc,
      input  out_valid, out_pc, out_pc_plus4, out_instr,
      output out_ready
   );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch: PC generator, credit-limited imem requests, FWFT PC/instr queue to decode.
// Response -> out_* in 1 cycle; requests stall when in-flight + queued reaches DEPTH, out_* holds while !out_ready.
module fetch_queue_unit #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input logic                 clk,
   input logic                 rst,
   fetch_queue_unit_if.master  bus
);
   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = PW + 1;
   localparam int CW1 = CW + 1;
   localparam logic [CW-1:0] FULL   = CW'(DEPTH);
   localparam logic [CW:0]   FULL_X = CW1'(DEPTH);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } entry_t;

   entry_t          q_mem [DEPTH];
   entry_t          head;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   drop_cnt;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] resp_pc;
   logic [CW:0]     live_total;
   logic            credit_ok;
   logic            req_fire;
   logic            resp_drop;
   logic            push;
   logic            pop;

   // Live in-flight responses plus queued entries must fit the queue, so a push never overflows.
   always_comb begin
      live_total = {1'b0, outstanding - drop_cnt} + {1'b0, count};
      credit_ok  = (outstanding < FULL) && (live_total < FULL_X);

      bus.imem_req_valid = !rst && !bus.redirect_valid && credit_ok;
      bus.imem_req_addr  = fetch_pc;
      req_fire           = bus.imem_req_valid && bus.imem_req_ready;

      resp_drop = bus.imem_resp_valid && (drop_cnt != '0);
      push      = bus.imem_resp_valid && (drop_cnt == '0) && !bus.redirect_valid;

      bus.out_valid = (count != '0) && !bus.redirect_valid;
      pop           = bus.out_valid && bus.out_ready;

      head             = q_mem[rd_ptr];
      bus.out_pc       = (count != '0) ? head.pc    : '0;
      bus.out_instr    = (count != '0) ? head.instr : '0;
      bus.out_pc_plus4 = bus.out_pc + XLEN'(4);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         count       <= '0;
         outstanding <= '0;
         drop_cnt    <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else begin
         outstanding <= outstanding + CW'(req_fire) - CW'(bus.imem_resp_valid);
         if (bus.redirect_valid) begin
            // Everything still in flight is stale; a response landing now is discarded here.
            fetch_pc <= bus.redirect_pc;
            resp_pc  <= bus.redirect_pc;
            drop_cnt <= outstanding - CW'(bus.imem_resp_valid);
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
         end else begin
            if (req_fire) begin
               fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (resp_drop) begin
               drop_cnt <= drop_cnt - CW'(1);
            end
            if (push) begin
               wr_ptr  <= wr_ptr + PW'(1);
               resp_pc <= resp_pc + XLEN'(4);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_mem[wr_ptr] <= '{pc: resp_pc, instr: bus.imem_resp_instr};
      end
   end

   a_no_overflow : assert property (@(posedge clk) disable iff (rst)
      push |-> ((count != FULL) || pop));
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomised fetch-queue bench: in-order pipelined imem model, epoch-tagged scoreboard of expected decode stream.
module tb_fetch_queue_unit;
   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          due;
   } mreq_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   logic clk;
   logic rst;

   fetch_queue_unit_if #(.XLEN(32)) bus ();

   fetch_queue_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          last_due = 0;
   int          epoch = 0;
   int          p_rrdy = 100;
   int          p_ordy = 100;
   int          p_rd = 0;
   int          lat_lo = 1;
   int          lat_hi = 1;
   bit          force_rd = 1'b0;
   logic [31:0] force_pc = 32'h0;
   logic [31:0] exp_fetch = 32'h0;
   bit          s_ov = 1'b0;

   mreq_t       memq[$];
   ent_t        mq[$];
   logic [31:0] pop_log[$];
   logic [31:0] p4_log[$];
   logic [31:0] req_log[$];

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
   endfunction

   function automatic logic [31:0] qat(input logic [31:0] q[$], input int idx);
      if (idx < q.size()) return q[idx];
      return 32'hxxxx_xxxx;
   endfunction

   // One clock cycle: drive inputs after the falling edge, check, then advance the model.
   task automatic step();
      mreq_t       e;
      bit          rd;
      bit          deliver;
      bit          exp_rv;
      bit          exp_ov;
      int          live;
      int          d;
      logic [31:0] rpc;

      @(negedge clk);
      cyc++;
      rd  = force_rd || ($urandom_range(0, 99) < p_rd);
      rpc = force_rd ? force_pc : ($urandom & 32'hFFFF_FFFC);
      force_rd = 1'b0;
      deliver  = (memq.size() != 0) && (memq[0].due <= cyc);

      bus.redirect_valid  = rd;
      bus.redirect_pc     = rpc;
      bus.out_ready       = ($urandom_range(0, 99) < p_ordy);
      bus.imem_req_ready  = ($urandom_range(0, 99) < p_rrdy);
      bus.imem_resp_valid = deliver;
      bus.imem_resp_instr = deliver ? (memq[0].addr ^ 32'hA5A5_0000) : $urandom;
      #1;

      live = 0;
      foreach (memq[i]) if (memq[i].epoch == epoch) live++;
      exp_rv = !rd && (memq.size() < DEPTH) && (live + mq.size() < DEPTH);
      exp_ov = (mq.size() != 0) && !rd;
      s_ov   = bus.out_valid;

      chk("imem_req_valid", {31'b0, bus.imem_req_valid}, {31'b0, exp_rv});
      if (exp_rv) chk("imem_req_addr", bus.imem_req_addr, exp_fetch);
      chk("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_ov});
      if (mq.size() != 0) begin
         chk("out_pc", bus.out_pc, mq[0].pc);
         chk("out_instr", bus.out_instr, mq[0].instr);
         chk("out_pc_plus4", bus.out_pc_plus4, mq[0].pc + 32'd4);
      end else begin
         chk("out_pc_empty", bus.out_pc, 32'h0);
         chk("out_pc_plus4_empty", bus.out_pc_plus4, 32'h4);
      end

      if (deliver) e = memq.pop_front();
      if (exp_ov && bus.out_ready) begin
         pop_log.push_back(mq[0].pc);
         p4_log.push_back(bus.out_pc_plus4);
         void'(mq.pop_front());
      end
      if (rd) begin
         mq.delete();
         epoch++;
         exp_fetch = rpc;
      end else if (deliver && (e.epoch == epoch)) begin
         mq.push_back('{pc: e.addr, instr: e.addr ^ 32'hA5A5_0000});
      end
      if (exp_rv && bus.imem_req_ready) begin
         d = cyc + $urandom_range(lat_lo, lat_hi);
         if (d <= last_due) d = last_due + 1;
         last_due = d;
         memq.push_back('{addr: exp_fetch, epoch: epoch, due: d});
         req_log.push_back(exp_fetch);
         exp_fetch += 32'd4;
      end
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      force_rd = 1'b1;
      force_pc = pc;
      step();
   endtask

   initial begin
      int  n0;
      int  r0;
      int  k;
      bit  found;

      rst = 1'b1;
      bus.imem_req_ready  = 1'b0;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_instr = 32'h0;
      bus.redirect_valid  = 1'b0;
      bus.redirect_pc     = 32'h0;
      bus.out_ready       = 1'b0;

      repeat (2) @(negedge clk);
      #1;
      chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
      chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
      chk("rst_out_pc", bus.out_pc, 32'h0);
      chk("rst_out_instr", bus.out_instr, 32'h0);
      chk("rst_out_pc_plus4", bus.out_pc_plus4, 32'h4);
      rst = 1'b0;

      // Decode stalled: exactly DEPTH requests go out, head stays at the reset PC.
      p_ordy = 0;
      repeat (10) step();
      chk("stall_req_count", req_log.size(), 32'd4);
      chk("stall_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
      chk("stall_head_pc", bus.out_pc, 32'h0);
      chk("stall_head_instr", bus.out_instr, 32'hA5A5_0000);

      // Release: in-order drain, fetch resumes at 0x10, then one instruction per cycle.
      p_ordy = 100;
      repeat (12) step();
      chk("drain_pop0", qat(pop_log, 0), 32'h0);
      chk("drain_pop1", qat(pop_log, 1), 32'h4);
      chk("drain_pop3", qat(pop_log, 3), 32'hC);
      chk("drain_pop4", qat(pop_log, 4), 32'h10);
      chk("resume_req", qat(req_log, 4), 32'h10);
      chk("stream_pops", pop_log.size(), 32'd12);

      // Longer memory latency, redirect with responses in flight.
      lat_lo = 3; lat_hi = 3;
      repeat (8) step();
      n0 = pop_log.size(); r0 = req_log.size();
      redirect_to(32'h100);
      repeat (12) step();
      chk("redir_first_req", qat(req_log, r0), 32'h100);
      chk("redir_first_pop", qat(pop_log, n0), 32'h100);

      // Redirect coinciding with a response and a pending pop; 3-cycle recovery.
      lat_lo = 1; lat_hi = 1;
      repeat (6) step();
      redirect_to(32'h200);
      found = 1'b0;
      k = 0;
      for (int i = 1; i <= 10 && !found; i++) begin
         step();
         if (s_ov) begin
            found = 1'b1;
            k = i;
         end
      end
      chk("redir_to_valid_cycles", k, 32'd3);

      // Address wrap.
      n0 = pop_log.size(); r0 = req_log.size();
      redirect_to(32'hFFFF_FFFC);
      repeat (6) step();
      chk("wrap_req0", qat(req_log, r0), 32'hFFFF_FFFC);
      chk("wrap_req1", qat(req_log, r0 + 1), 32'h0);
      chk("wrap_pop0", qat(pop_log, n0), 32'hFFFF_FFFC);
      chk("wrap_plus4", qat(p4_log, n0), 32'h0);

      // Random traffic.
      p_rrdy = 70; p_ordy = 70; p_rd = 3; lat_lo = 1; lat_hi = 4;
      repeat (1500) step();

      // Async reset between clock edges.
      p_rrdy = 100; p_ordy = 100; p_rd = 0; lat_lo = 1; lat_hi = 1;
      repeat (6) step();
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
      chk("async_rst_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
      memq.delete();
      mq.delete();
      epoch++;
      exp_fetch = 32'h0;
      bus.imem_resp_valid = 1'b0;
      bus.imem_req_ready  = 1'b0;
      bus.redirect_valid  = 1'b0;
      @(negedge clk);
      #2;
      rst = 1'b0;
      n0 = pop_log.size(); r0 = req_log.size();
      repeat (6) step();
      chk("post_rst_req0", qat(req_log, r0), 32'h0);
      chk("post_rst_pop0", qat(pop_log, n0), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
